// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_req_arbiter
// Description : Round-robin arbiter sharing one fixed-latency alu between two
//               requesters. One operation in flight; operands are registered
//               toward the alu, and the result is returned tagged with the
//               winning port id.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_req_arbiter #(
    parameter int W       = 4,
    parameter int RW      = 8,
    parameter int ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [W-1:0]  req0_op1,
    input  logic [W-1:0]  req0_op2,
    input  logic [2:0]    req0_opcode,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [W-1:0]  req1_op1,
    input  logic [W-1:0]  req1_op2,
    input  logic [2:0]    req1_opcode,

    output logic [W-1:0]  alu_op1,
    output logic [W-1:0]  alu_op2,
    output logic [2:0]    alu_opcode,
    input  logic [RW-1:0] alu_res,

    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [RW-1:0] rsp_data
);

    // WAIT runs ALU_LAT cycles: load LAT-1, capture when the counter hits 0.
    localparam logic [3:0] C_CNT_LOAD = 4'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_accept;

    logic [W-1:0]    r_alu_op1;
    logic [W-1:0]    r_alu_op2;
    logic [2:0]      r_alu_opcode;
    logic            r_rsp_valid;
    logic            r_rsp_id;
    logic [RW-1:0]   r_rsp_data;
    logic [3:0]      r_cnt;
    logic            r_last;

    // Grant selection (IDLE only, suppressed by reset) and next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rst) begin
                    // On a tie the port that did not win last time goes next.
                    if (req0_valid && (!req1_valid || r_last)) begin
                        w_gnt0 = 1'b1;
                    end else if (req1_valid) begin
                        w_gnt1 = 1'b1;
                    end
                end
                if (w_gnt0 || w_gnt1) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Ready is only ever raised toward a valid port, so a grant is an accept.
    assign w_accept = w_gnt0 | w_gnt1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand latch, latency counter, response capture and round-robin memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
            r_alu_opcode <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
            r_cnt        <= 4'd0;
            r_last       <= 1'b1;
        end else begin
            if (w_accept) begin
                r_alu_op1    <= w_gnt1 ? req1_op1    : req0_op1;
                r_alu_op2    <= w_gnt1 ? req1_op2    : req0_op2;
                r_alu_opcode <= w_gnt1 ? req1_opcode : req0_opcode;
                r_rsp_id     <= w_gnt1;
                r_last       <= w_gnt1;
                r_cnt        <= C_CNT_LOAD;
            end
            if (r_state == S_WAIT) begin
                if (r_cnt == 4'd0) begin
                    r_rsp_data  <= alu_res;
                    r_rsp_valid <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
            if ((r_state == S_RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign alu_op1    = r_alu_op1;
    assign alu_op2    = r_alu_op2;
    assign alu_opcode = r_alu_opcode;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_alu_req_arbiter
// Description : Self-checking bench for alu_req_arbiter. Three instances with
//               ALU_LAT = 1, 3 and 15 are driven independently; expectations
//               come from a transaction-level model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_req_arbiter;

    localparam int W  = 4;
    localparam int RW = 8;

    logic           clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst  [3];
    logic [1:0]     vld  [3];
    logic           rdy0 [3];
    logic           rdy1 [3];
    logic [W-1:0]   op1  [3][2];
    logic [W-1:0]   op2  [3][2];
    logic [2:0]     opc  [3][2];
    logic [W-1:0]   aop1 [3];
    logic [W-1:0]   aop2 [3];
    logic [2:0]     aopc [3];
    logic [RW-1:0]  ares [3];
    logic           rvld [3];
    logic           rrdy [3];
    logic           rid  [3];
    logic [RW-1:0]  rdata[3];

    int total = 0;
    int bad   = 0;
    bit m_last[3];   // model: port that won the most recent grant

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            alu_req_arbiter #(
                .W      (W),
                .RW     (RW),
                .ALU_LAT(g == 0 ? 1 : (g == 1 ? 3 : 15))
            ) u_dut (
                .clk        (clk),
                .rst        (rst[g]),
                .req0_valid (vld[g][0]),
                .req0_ready (rdy0[g]),
                .req0_op1   (op1[g][0]),
                .req0_op2   (op2[g][0]),
                .req0_opcode(opc[g][0]),
                .req1_valid (vld[g][1]),
                .req1_ready (rdy1[g]),
                .req1_op1   (op1[g][1]),
                .req1_op2   (op2[g][1]),
                .req1_opcode(opc[g][1]),
                .alu_op1    (aop1[g]),
                .alu_op2    (aop2[g]),
                .alu_opcode (aopc[g]),
                .alu_res    (ares[g]),
                .rsp_valid  (rvld[g]),
                .rsp_ready  (rrdy[g]),
                .rsp_id     (rid[g]),
                .rsp_data   (rdata[g])
            );
        end
    endgenerate

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 15);
    endfunction

    task automatic scramble(input int k);
        for (int p = 0; p < 2; p++) begin
            op1[k][p] = W'($urandom);
            op2[k][p] = W'($urandom);
            opc[k][p] = 3'($urandom);
        end
    endtask

    // One complete transaction on instance k. Called and returns at posedge+1
    // with the instance idle. The accepting edge counts as edge 1, so the
    // response is visible after edge ALU_LAT+1 counted that way.
    task automatic issue(input int k, input bit v0, input bit v1, input int stall,
                         input bit fix, input bit chk_clear);
        int               lat;
        int               win;
        logic [1:0]       erdy;
        logic [W-1:0]     a[2];
        logic [W-1:0]     b[2];
        logic [2:0]       o[2];
        logic [2*W+2:0]   eops;
        logic [RW-1:0]    cap;
        lat = lat_of(k);
        cap = '0;
        for (int p = 0; p < 2; p++) begin
            a[p] = fix ? 4'hA : W'($urandom);
            b[p] = fix ? 4'hA : W'($urandom);
            o[p] = fix ? 3'b000 : 3'($urandom);
            op1[k][p] = a[p];
            op2[k][p] = b[p];
            opc[k][p] = o[p];
        end
        vld[k]  = {v1, v0};
        win     = (v0 && v1) ? (m_last[k] ? 0 : 1) : (v1 ? 1 : 0);
        erdy    = (win == 1) ? 2'b10 : 2'b01;
        eops    = {a[win], b[win], o[win]};
        rrdy[k] = (stall == 0);
        @(negedge clk);
        total++;
        if ({rdy1[k], rdy0[k]} !== erdy) begin
            bad++;
            $display("FAIL grant k=%0d got=%b required=%b", k, {rdy1[k], rdy0[k]}, erdy);
        end
        if (chk_clear) begin
            total++;
            if ({aop1[k], aop2[k], aopc[k], rvld[k], rid[k], rdata[k]} !== '0) begin
                bad++;
                $display("FAIL post_reset_clear k=%0d got=%h required=0", k,
                         {aop1[k], aop2[k], aopc[k], rvld[k], rid[k], rdata[k]});
            end
        end
        @(posedge clk); #1;
        m_last[k] = (win == 1);
        // Both ports keep requesting with fresh operands: nothing may change.
        vld[k] = 2'b11;
        scramble(k);
        for (int i = 1; i <= lat; i++) begin
            ares[k] = RW'($urandom);
            @(negedge clk);
            total++;
            if ({rvld[k], rdy1[k], rdy0[k]} !== 3'b000) begin
                bad++;
                $display("FAIL wait_quiet k=%0d cyc=%0d got=%b required=000", k, i,
                         {rvld[k], rdy1[k], rdy0[k]});
            end
            total++;
            if ({aop1[k], aop2[k], aopc[k]} !== eops) begin
                bad++;
                $display("FAIL wait_operands k=%0d cyc=%0d got=%h required=%h", k, i,
                         {aop1[k], aop2[k], aopc[k]}, eops);
            end
            cap = ares[k];
            @(posedge clk); #1;
            scramble(k);
        end
        for (int s = 0; s <= stall; s++) begin
            ares[k] = RW'($urandom);
            if (s == stall) rrdy[k] = 1'b1;
            @(negedge clk);
            total++;
            if ({rvld[k], rid[k], rdata[k]} !== {1'b1, 1'(win), cap}) begin
                bad++;
                $display("FAIL response k=%0d stall=%0d got=%h required=%h", k, s,
                         {rvld[k], rid[k], rdata[k]}, {1'b1, 1'(win), cap});
            end
            total++;
            if ({aop1[k], aop2[k], aopc[k], rdy1[k], rdy0[k]} !== {eops, 2'b00}) begin
                bad++;
                $display("FAIL resp_hold k=%0d stall=%0d got=%h required=%h", k, s,
                         {aop1[k], aop2[k], aopc[k], rdy1[k], rdy0[k]}, {eops, 2'b00});
            end
            @(posedge clk); #1;
            scramble(k);
        end
        vld[k]  = 2'b00;
        rrdy[k] = 1'b0;
        @(negedge clk);
        total++;
        if (rvld[k] !== 1'b0) begin
            bad++;
            $display("FAIL resp_done k=%0d got=%b required=0", k, rvld[k]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) rst[k] = 1'b1;
        vld[0] = 2'b01;
        repeat (2) begin
            @(posedge clk); #1;
            @(negedge clk);
            total++;
            if ({rdy1[0], rdy0[0], rvld[0]} !== 3'b000) begin
                bad++;
                $display("FAIL reset_ctrl got=%b required=000", {rdy1[0], rdy0[0], rvld[0]});
            end
            total++;
            if ({aop1[0], aop2[0], aopc[0], rid[0], rdata[0]} !== '0) begin
                bad++;
                $display("FAIL reset_data got=%h required=0",
                         {aop1[0], aop2[0], aopc[0], rid[0], rdata[0]});
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            rst[k]    = 1'b0;
            m_last[k] = 1'b1;
        end
        @(negedge clk);
        total++;
        if ({rdy1[0], rdy0[0]} !== 2'b01) begin
            bad++;
            $display("FAIL reset_release_ready got=%b required=01", {rdy1[0], rdy0[0]});
        end
        vld[0] = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic test_fairness();
        for (int n = 0; n < 4; n++) issue(0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_single_op();
        issue(0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_back_pressure();
        issue(0, 1'b1, 1'b0, 5, 1'b0, 1'b0);
        issue(0, 1'b1, 1'b1, 5, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        scramble(1);
        vld[1]  = 2'b11;
        rrdy[1] = 1'b1;
        @(negedge clk);
        total++;
        if ({rdy1[1], rdy0[1]} !== 2'b01) begin
            bad++;
            $display("FAIL midrst_grant got=%b required=01", {rdy1[1], rdy0[1]});
        end
        @(posedge clk); #1;
        vld[1] = 2'b10;
        @(negedge clk);
        total++;
        if (rvld[1] !== 1'b0) begin
            bad++;
            $display("FAIL midrst_wait got=%b required=0", rvld[1]);
        end
        @(posedge clk); #1;
        rst[1] = 1'b1;
        @(negedge clk);
        total++;
        if ({rdy1[1], rdy0[1], rvld[1]} !== 3'b000) begin
            bad++;
            $display("FAIL midrst_during got=%b required=000", {rdy1[1], rdy0[1], rvld[1]});
        end
        @(posedge clk); #1;
        rst[1]    = 1'b0;
        m_last[1] = 1'b1;
        issue(1, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_latency_sweep();
        issue(0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        issue(2, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        issue(2, 1'b1, 1'b1, 2, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [1:0] v;
        for (int n = 0; n < 12; n++) begin
            v = 2'($urandom_range(1, 3));
            issue(0, v[0], v[1], int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end
        for (int n = 0; n < 6; n++) begin
            v = 2'($urandom_range(1, 3));
            issue(1, v[0], v[1], int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k]    = 1'b1;
            vld[k]    = 2'b00;
            rrdy[k]   = 1'b0;
            ares[k]   = '0;
            m_last[k] = 1'b1;
            scramble(k);
        end
        test_reset();
        test_fairness();
        test_single_op();
        test_back_pressure();
        test_reset_mid_op();
        test_latency_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
